drp_reconf_master: RTL and testbench



---
 rtl/drp_reconf_master_pkg.sv | 63 ++++++
 rtl/drp_reconf_master_timeout.sv | 39 +++
 rtl/drp_reconf_master.sv | 200 ++++++++++++++++++++
 tb/tb_drp_reconf_master.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drp_reconf_master_pkg.sv
// -----------------------------------------------------------------------------
// drp_defs
// Shared definitions for the PLL DRP reconfiguration master:
//   - controller state encoding
//   - DRP register address map of the PLL
//   - keep-mask convention and the read-modify-write merge helper
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package drp_defs;

    localparam int DRP_ADDR_W = 7;
    localparam int DRP_DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD        = 3'd1,
        ST_RD_WAIT   = 3'd2,
        ST_WR        = 3'd3,
        ST_WR_WAIT   = 3'd4,
        ST_NEXT      = 3'd5,
        ST_LOCK_WAIT = 3'd6,
        ST_FINISH    = 3'd7
    } drp_state_t;

    // Output divider registers (ClkReg1 / ClkReg2 pairs)
    localparam logic [6:0] ADDR_CLKOUT5_REG1 = 7'h06;
    localparam logic [6:0] ADDR_CLKOUT5_REG2 = 7'h07;
    localparam logic [6:0] ADDR_CLKOUT0_REG1 = 7'h08;
    localparam logic [6:0] ADDR_CLKOUT0_REG2 = 7'h09;
    localparam logic [6:0] ADDR_CLKOUT1_REG1 = 7'h0A;
    localparam logic [6:0] ADDR_CLKOUT1_REG2 = 7'h0B;
    localparam logic [6:0] ADDR_CLKOUT2_REG1 = 7'h0C;
    localparam logic [6:0] ADDR_CLKOUT2_REG2 = 7'h0D;
    localparam logic [6:0] ADDR_CLKOUT3_REG1 = 7'h0E;
    localparam logic [6:0] ADDR_CLKOUT3_REG2 = 7'h0F;
    localparam logic [6:0] ADDR_CLKOUT4_REG1 = 7'h10;
    localparam logic [6:0] ADDR_CLKOUT4_REG2 = 7'h11;
    localparam logic [6:0] ADDR_CLKOUT6_REG1 = 7'h12;
    localparam logic [6:0] ADDR_CLKOUT6_REG2 = 7'h13;
    // Feedback divider, input divider, lock and filter settings
    localparam logic [6:0] ADDR_CLKFB_REG1   = 7'h14;
    localparam logic [6:0] ADDR_CLKFB_REG2   = 7'h15;
    localparam logic [6:0] ADDR_DIVCLK_REG   = 7'h16;
    localparam logic [6:0] ADDR_LOCK_REG1    = 7'h18;
    localparam logic [6:0] ADDR_LOCK_REG2    = 7'h19;
    localparam logic [6:0] ADDR_LOCK_REG3    = 7'h1A;
    localparam logic [6:0] ADDR_POWER_REG    = 7'h28;
    localparam logic [6:0] ADDR_FILT_REG1    = 7'h4E;
    localparam logic [6:0] ADDR_FILT_REG2    = 7'h4F;

    // Mask bit 1 keeps the bit read from the PLL, 0 takes the command bit.
    localparam logic MASK_KEEP = 1'b1;
    localparam logic MASK_TAKE = 1'b0;

    function automatic logic [DRP_DATA_W-1:0] drp_merge(
        input logic [DRP_DATA_W-1:0] rd_val,
        input logic [DRP_DATA_W-1:0] new_val,
        input logic [DRP_DATA_W-1:0] keep_mask
    );
        return (rd_val & keep_mask) | (new_val & ~keep_mask);
    endfunction

endpackage

// File: rtl/drp_reconf_master_timeout.sv
// -----------------------------------------------------------------------------
// drp_timeout
// Loadable saturating down-counter shared by all wait states of the DRP
// master. Loading arms it with the wait limit; it then counts down while
// enabled and sticks at zero, where o_expired is raised.
//   i_clk       clock
//   i_rst_n     async active-low reset
//   i_load      (re)arm counter with i_load_val
//   i_load_val  wait limit in cycles
//   i_en        count this cycle
//   o_expired   counter has reached zero
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module drp_timeout #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/drp_reconf_master.sv
// -----------------------------------------------------------------------------
// drp_reconf_master
// DRP initiator for PLL dynamic reconfiguration. Each accepted command is
// applied as a read-modify-write of one DRP register. The PLL is held in
// reset from the first accepted command until the DRDY of the last write,
// after which the master waits for LOCKED and pulses o_done.
//   i_clk / i_rst_n        DRP clock, async active-low reset
//   i_cmd_valid/o_cmd_ready command handshake
//   i_cmd_addr/data/mask   register, new bits, keep-mask (1 = keep)
//   i_cmd_last             last command of the sequence
//   o_daddr/o_den/o_dwe/o_di, i_do/i_drdy   DRP port
//   i_locked / o_pll_rst   PLL lock in, PLL reset out (active high)
//   o_busy / o_done / o_error  status: not idle, end pulse, sticky timeout
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module drp_reconf_master
    import drp_defs::*;
#(
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [6:0]  i_cmd_addr,
    input  logic [15:0] i_cmd_data,
    input  logic [15:0] i_cmd_mask,
    input  logic        i_cmd_last,
    output logic [6:0]  o_daddr,
    output logic        o_den,
    output logic        o_dwe,
    output logic [15:0] o_di,
    input  logic [15:0] i_do,
    input  logic        i_drdy,
    input  logic        i_locked,
    output logic        o_pll_rst,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error
);

    localparam int MAX_TO = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
    localparam int CNT_W  = $clog2(MAX_TO) + 1;

    drp_state_t  r_state;
    drp_state_t  w_state_nxt;

    logic [6:0]  r_daddr;
    logic [15:0] r_di;
    logic [15:0] r_data;
    logic [15:0] r_mask;
    logic        r_last;
    logic        r_pll_rst;
    logic        r_error;

    logic             w_accept;
    logic             w_rd_done;
    logic             w_release;
    logic             w_timeout;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_cnt_en;
    logic             w_expired;

    drp_timeout #(
        .CNT_W (CNT_W)
    ) u_timeout (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_en       (w_cnt_en),
        .o_expired  (w_expired)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The counter is armed on the edge that enters a wait state, so the
    // first wait cycle already sees the full limit.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_rd_done   = 1'b0;
        w_release   = 1'b0;
        w_timeout   = 1'b0;
        w_load      = 1'b0;
        w_load_val  = CNT_W'(DRDY_TIMEOUT);
        unique case (r_state)
            ST_IDLE, ST_NEXT: begin
                if (i_cmd_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RD;
                end
            end
            ST_RD: begin
                w_load      = 1'b1;
                w_state_nxt = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (i_drdy) begin
                    w_rd_done   = 1'b1;
                    w_state_nxt = ST_WR;
                end else if (w_expired) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_FINISH;
                end
            end
            ST_WR: begin
                w_load      = 1'b1;
                w_state_nxt = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (i_drdy) begin
                    if (r_last) begin
                        w_release   = 1'b1;
                        w_load      = 1'b1;
                        w_load_val  = CNT_W'(LOCK_TIMEOUT);
                        w_state_nxt = ST_LOCK_WAIT;
                    end else begin
                        w_state_nxt = ST_NEXT;
                    end
                end else if (w_expired) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_FINISH;
                end
            end
            ST_LOCK_WAIT: begin
                if (i_locked) begin
                    w_state_nxt = ST_FINISH;
                end else if (w_expired) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_FINISH;
                end
            end
            ST_FINISH: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_cnt_en = (r_state == ST_RD_WAIT) || (r_state == ST_WR_WAIT) ||
                      (r_state == ST_LOCK_WAIT);

    // DADDR is loaded on the accept edge, i.e. exactly when the read DEN
    // starts; DI only changes on the edge into WR. Both hold otherwise.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_daddr   <= '0;
            r_di      <= '0;
            r_data    <= '0;
            r_mask    <= '0;
            r_last    <= 1'b0;
            r_pll_rst <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_daddr   <= i_cmd_addr;
                r_data    <= i_cmd_data;
                r_mask    <= i_cmd_mask;
                r_last    <= i_cmd_last;
                r_pll_rst <= 1'b1;
                if (r_state == ST_IDLE) begin
                    r_error <= 1'b0;
                end
            end
            if (w_rd_done) begin
                r_di <= drp_merge(i_do, r_data, r_mask);
            end
            if (w_release || w_timeout) begin
                r_pll_rst <= 1'b0;
            end
            if (w_timeout) begin
                r_error <= 1'b1;
            end
        end
    end

    // Ready is gated by reset so it is low while reset is asserted even
    // though the state register already reads IDLE.
    assign o_cmd_ready = i_rst_n && ((r_state == ST_IDLE) || (r_state == ST_NEXT));
    assign o_den       = (r_state == ST_RD) || (r_state == ST_WR);
    assign o_dwe       = (r_state == ST_WR);
    assign o_daddr     = r_daddr;
    assign o_di        = r_di;
    assign o_pll_rst   = r_pll_rst;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = (r_state == ST_FINISH);
    assign o_error     = r_error;

endmodule

// File: tb/tb_drp_reconf_master.sv
`timescale 1ns/1ps
module tb_drp_reconf_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [6:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic [15:0] cmd_mask;
    logic        cmd_last;
    logic [6:0]  daddr;
    logic        den;
    logic        dwe;
    logic [15:0] di;
    logic [15:0] do_i;
    logic        drdy;
    logic        locked;
    logic        pll_rst;
    logic        busy;
    logic        done;
    logic        error;

    drp_reconf_master #(
        .DRDY_TIMEOUT (64),
        .LOCK_TIMEOUT (4096)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_addr  (cmd_addr),
        .i_cmd_data  (cmd_data),
        .i_cmd_mask  (cmd_mask),
        .i_cmd_last  (cmd_last),
        .o_daddr     (daddr),
        .o_den       (den),
        .o_dwe       (dwe),
        .o_di        (di),
        .i_do        (do_i),
        .i_drdy      (drdy),
        .i_locked    (locked),
        .o_pll_rst   (pll_rst),
        .o_busy      (busy),
        .o_done      (done),
        .o_error     (error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;

    // DRP responder model
    logic [15:0] mem [128];
    bit          resp_en = 1'b1;
    int          resp_dly = 1;
    int          pend_cnt = 0;
    logic [15:0] pend_do = '0;
    logic        log_we   [16];
    logic [6:0]  log_addr [16];
    logic [15:0] log_data [16];
    int          log_n = 0;

    // monitors
    int  done_n = 0;
    int  done_cyc = 0;
    int  pll_fall_cyc = 0;
    logic prev_pll = 1'b0;
    int  wr_den_n = 0;
    int  rdy_busy_n = 0;
    int  busy_nopll_n = 0;

    typedef struct {
        logic [6:0]  addr;
        logic [15:0] data;
        logic [15:0] mask;
        logic [15:0] do_val;
        logic [15:0] exp_di;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (resp_en) begin
            drdy = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    drdy = 1'b1;
                    do_i = pend_do;
                end
            end
            if (den) begin
                if (log_n < 16) begin
                    log_we[log_n]   = dwe;
                    log_addr[log_n] = daddr;
                    log_data[log_n] = dwe ? di : mem[daddr];
                    log_n++;
                end
                if (dwe) mem[daddr] = di;
                else     pend_do = mem[daddr];
                if (resp_dly > 0) pend_cnt = resp_dly;
            end
        end
        if (done) begin
            done_n++;
            done_cyc = cyc;
        end
        if (prev_pll && !pll_rst) pll_fall_cyc = cyc;
        prev_pll = pll_rst;
        if (den && dwe) wr_den_n++;
        if (cmd_ready && busy) rdy_busy_n++;
        if (busy && !pll_rst) busy_nopll_n++;
    endtask

    task automatic send_cmd(input logic [6:0] a, input logic [15:0] d,
                            input logic [15:0] m, input logic l);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_mask  = m;
        cmd_last  = l;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        chk("cmd_ready_wait", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_done(input int max);
        int n;
        n = 0;
        while (!done && n < max) begin
            tick();
            n++;
        end
        chk("done_seen", done, 1);
    endtask

    task automatic run_single(input vec_t v);
        mem[v.addr] = v.do_val;
        locked   = 1'b0;
        resp_en  = 1'b1;
        resp_dly = 1;
        log_n    = 0;
        send_cmd(v.addr, v.data, v.mask, 1'b1);
        chk("rd_den_dwe", {den, dwe}, 2'b10);
        chk("rd_daddr", daddr, v.addr);
        chk("pll_rst_on", pll_rst, 1);
        tick();
        chk("rdwait_den", den, 0);
        tick();
        chk("wr_den_dwe", {den, dwe}, 2'b11);
        chk("wr_di", di, v.exp_di);
        chk("wr_daddr", daddr, v.addr);
        tick();
        chk("wrwait_pll_rst", pll_rst, 1);
        tick();
        chk("lockwait_pll_rst", pll_rst, 0);
        chk("lockwait_done", done, 0);
        tick();
        chk("lockwait_hold_done", done, 0);
        locked = 1'b1;
        tick();
        chk("finish_done", done, 1);
        chk("finish_error", error, 0);
        tick();
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("mem_written", mem[v.addr], v.exp_di);
        locked = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int d0;
        logic        exp_we   [6];
        logic [6:0]  exp_addr [6];

        vecs[0] = '{7'h08, 16'h1041, 16'hF000, 16'hA5A5, 16'hA041};
        vecs[1] = '{7'h4E, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234};
        vecs[2] = '{7'h28, 16'h0000, 16'hFFFF, 16'h5A5A, 16'h5A5A};
        vecs[3] = '{7'h16, 16'hFFFF, 16'h00FF, 16'h1234, 16'hFF34};
        vecs[4] = '{7'h18, 16'hAAAA, 16'h5555, 16'h0F0F, 16'hAFAF};

        for (int i = 0; i < 128; i++) mem[i] = '0;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0;
        cmd_mask = '0; cmd_last = 1'b0; do_i = '0; drdy = 1'b0; locked = 1'b0;

        // reset values
        #22;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_den", den, 0);
        chk("rst_dwe", dwe, 0);
        chk("rst_daddr", daddr, 0);
        chk("rst_di", di, 0);
        chk("rst_pll_rst", pll_rst, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", cmd_ready, 1);
        chk("post_rst_busy", busy, 0);

        // table-driven single commands
        for (int i = 0; i < 5; i++) run_single(vecs[i]);

        // three-command sequence
        mem[7'h14] = 16'h1234;
        mem[7'h15] = 16'h00FF;
        mem[7'h16] = 16'hC3C3;
        locked = 1'b1;
        log_n = 0; rdy_busy_n = 0; busy_nopll_n = 0; done_n = 0;
        send_cmd(7'h14, 16'h0A0A, 16'hF0F0, 1'b0);
        a = acc_cyc;
        send_cmd(7'h15, 16'hFFFF, 16'hFFFF, 1'b0);
        send_cmd(7'h16, 16'h0011, 16'hFF00, 1'b1);
        wait_done(50);
        chk("seq_done_latency", done_cyc - a, 15);
        chk("seq_log_n", log_n, 6);
        exp_we   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_addr = '{7'h14, 7'h14, 7'h15, 7'h15, 7'h16, 7'h16};
        for (int i = 0; i < 6; i++) begin
            chk("seq_log_we", log_we[i], exp_we[i]);
            chk("seq_log_addr", log_addr[i], exp_addr[i]);
        end
        chk("seq_mem14", mem[7'h14], 16'h1A3A);
        chk("seq_mem15", mem[7'h15], 16'h00FF);
        chk("seq_mem16", mem[7'h16], 16'hC311);
        chk("seq_ready_in_next", rdy_busy_n, 2);
        chk("seq_busy_no_pll_rst", busy_nopll_n, 2);
        tick();
        chk("seq_done_count", done_n, 1);
        locked = 1'b0;

        // read DRDY never returned
        resp_dly = 0; log_n = 0; wr_den_n = 0;
        send_cmd(7'h0A, 16'h1111, 16'h0000, 1'b1);
        a = acc_cyc;
        wait_done(200);
        chk("rdto_latency", done_cyc - a, 66);
        chk("rdto_error", error, 1);
        chk("rdto_pll_rst", pll_rst, 0);
        chk("rdto_no_write", wr_den_n, 0);
        chk("rdto_log_n", log_n, 1);
        tick();
        chk("rdto_idle_busy", busy, 0);
        chk("rdto_error_sticky", error, 1);
        resp_dly = 1;

        // LOCKED held low
        locked = 1'b0;
        send_cmd(7'h0C, 16'h2222, 16'h0000, 1'b1);
        chk("lkto_error_cleared", error, 0);
        wait_done(5000);
        chk("lkto_latency", done_cyc - pll_fall_cyc, 4097);
        chk("lkto_error", error, 1);
        chk("lkto_pll_rst", pll_rst, 0);
        tick();

        // reset pulse during WR_WAIT
        resp_dly = 3;
        send_cmd(7'h0E, 16'h3333, 16'h0000, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        chk("rstmid_wr_seen", wr_den_n > 0, 1);
        tick();
        chk("rstmid_in_wait_busy", {busy, den, pll_rst}, 3'b101);
        d0 = done_n;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_den", den, 0);
        chk("rstmid_pll_rst", pll_rst, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_ready", cmd_ready, 0);
        chk("rstmid_daddr", daddr, 0);
        pend_cnt = 0;
        drdy = 1'b0;
        #10;
        rst_n = 1'b1;
        tick();
        chk("rstmid_ready_after", cmd_ready, 1);
        chk("rstmid_busy_after", busy, 0);
        tick();
        chk("rstmid_no_done", done_n - d0, 0);
        resp_dly = 1;

        // DRDY in IDLE and coincident with DEN is ignored
        resp_en = 1'b0;
        drdy = 1'b1;
        do_i = 16'hFFFF;
        tick();
        chk("idle_drdy_busy", busy, 0);
        chk("idle_drdy_den", den, 0);
        send_cmd(7'h4F, 16'h00F0, 16'hFF0F, 1'b1);
        chk("co_rd_den", den, 1);
        tick();
        drdy = 1'b0;
        chk("co_rdwait_den", den, 0);
        tick();
        chk("co_rdwait_hold_den", den, 0);
        drdy = 1'b1;
        do_i = 16'h1111;
        tick();
        chk("co_wr_den_dwe", {den, dwe}, 2'b11);
        chk("co_wr_di", di, 16'h11F1);
        tick();
        drdy = 1'b0;
        chk("co_wrwait_pll", pll_rst, 1);
        tick();
        chk("co_wrwait_hold_pll", pll_rst, 1);
        chk("co_wrwait_den", den, 0);
        drdy = 1'b1;
        tick();
        drdy = 1'b0;
        chk("co_lockwait_pll", pll_rst, 0);
        locked = 1'b1;
        tick();
        chk("co_done", done, 1);
        tick();
        chk("co_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
